psum_accumulator_quant: RTL and testbench

- Sits directly downstream of the 4-lane 16-bit inner-product stage.
- Consumes its signed 32-bit partial dot products over a valid/ready handshake.
- Accumulates a configured number of partials per output neuron into a wide accumulator.
- Requantizes the sum to 16 bits (arithmetic shift, round-half-up, optional ReLU, saturation) and presents one result per job on an output handshake.

---
 rtl/psum_accumulator_quant.sv | 82 ++++++++
 tb/tb_psum_accumulator_quant.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_quant.sv
// psum_accumulator_quant: accumulates signed partial dot products per neuron and requantizes them to OUT_W bits
module psum_accumulator_quant #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu,
    input  logic             psum_valid,
    output logic             psum_ready,
    input  logic [31:0]      psum_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, QUANT = 2'd2, OUTPUT = 2'd3;
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
    logic [1:0] state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt, len;
    logic [4:0] shift;
    logic relu;
    logic signed [ACC_W:0] ext, half, sum, r, rr;
    logic hi, lo;
    logic [OUT_W-1:0] q;
    assign psum_ready = state == ACCUM;
    assign out_valid  = state == OUTPUT;
    assign busy       = state != IDLE;
    // requantize: one extra bit keeps the rounding bias from overflowing, then ReLU and clip
    always_comb begin
        ext  = {acc[ACC_W-1], acc};
        half = (shift == 5'd0) ? '0 : (ACC_W+1)'(1) << (shift - 5'd1);
        sum  = ext + half;
        r    = sum >>> shift;
        rr   = (relu && r[ACC_W]) ? '0 : r;
        hi   = rr > MAXV;
        lo   = rr < MINV;
        q    = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : rr[OUT_W-1:0];
    end
    // job sequencing, accumulation and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len      <= '0;
            shift    <= '0;
            relu     <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && cfg_len != '0) begin
                    len   <= cfg_len;
                    shift <= cfg_shift;
                    relu  <= cfg_relu;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (psum_valid) begin
                    acc <= acc + {{(ACC_W-32){psum_data[31]}}, psum_data};
                    cnt <= cnt + 1'b1;
                    if (cnt == len - 1'b1) state <= QUANT;
                end
                QUANT: begin
                    out_data <= q;
                    out_sat  <= hi | lo;
                    state    <= OUTPUT;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_accumulator_quant.sv
// tb_psum_accumulator_quant: directed scoreboard bench for psum_accumulator_quant
module tb_psum_accumulator_quant;
    typedef struct {int d; logic s;} exp_t;
    logic clk, reset, start, cfg_relu, psum_valid, psum_ready, out_valid, out_ready, out_sat, busy;
    logic [7:0] cfg_len;
    logic [4:0] cfg_shift;
    logic [31:0] psum_data;
    logic [15:0] out_data;
    exp_t q[$];
    int tests = 0, fails = 0, hs = 0;

    psum_accumulator_quant dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic fail(input string n);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", n);
    endtask

    // monitor: pop the scoreboard on every output handshake
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            hs++;
            if (q.size() == 0) fail("unexpected_output");
            else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", $signed(out_data), e.d);
                chk("out_sat", int'(out_sat), int'(e.s));
            end
        end
    end

    task automatic start_job(input int l, input int s, input logic r);
        start = 1; cfg_len = 8'(l); cfg_shift = 5'(s); cfg_relu = r;
        @(posedge clk); #1;
        start = 0; cfg_len = 8'hAA; cfg_shift = 5'd31; cfg_relu = ~r;
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        psum_valid = 1; psum_data = d;
        while (!psum_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!psum_ready) fail("send_timeout");
        @(posedge clk); #1;
        psum_valid = 0; psum_data = 32'hDEADBEEF;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (busy) fail("idle_timeout");
    endtask

    task automatic job(input int l, input int s, input logic r, input logic [31:0] a, b, c,
                       input int gap, input int ed, input logic es);
        logic [31:0] p[3];
        p = '{a, b, c};
        q.push_back('{ed, es});
        start_job(l, s, r);
        for (int i = 0; i < l; i++) begin
            send(p[i]);
            if (gap > 0 && i < l - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_idle();
    endtask

    initial begin
        reset = 1; start = 0; cfg_len = 0; cfg_shift = 0; cfg_relu = 0;
        psum_valid = 0; psum_data = 0; out_ready = 1;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_psum_ready", int'(psum_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        // basic sum with latency checks
        q.push_back('{75, 1'b0});
        start_job(3, 0, 0);
        chk("accum_busy", int'(busy), 1);
        chk("accum_ready", int'(psum_ready), 1);
        send(100); send(-30); send(5);
        chk("quant_out_valid", int'(out_valid), 0);
        chk("quant_ready", int'(psum_ready), 0);
        @(posedge clk); #1;
        chk("output_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        chk("post_hs_busy", int'(busy), 0);
        chk("post_hs_valid", int'(out_valid), 0);
        // rounding, saturation and ReLU
        job(2, 4, 0, 40, 0, 0, 0, 3, 1'b0);
        job(2, 4, 0, -40, 0, 0, 0, -2, 1'b0);
        job(2, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 32767, 1'b1);
        job(1, 0, 0, -100000, 0, 0, 0, -32768, 1'b1);
        job(1, 0, 1, -100000, 0, 0, 0, 0, 1'b0);
        // backpressure with an ignored start pulse
        q.push_back('{1234, 1'b0});
        out_ready = 0;
        start_job(1, 0, 0);
        send(1234);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", $signed(out_data), 1234);
            chk("bp_sat", int'(out_sat), 0);
            chk("bp_ready", int'(psum_ready), 0);
            start = (i == 2); cfg_len = 8'd2;
            @(posedge clk); #1;
        end
        start = 0;
        begin
            int h0;
            h0 = hs;
            out_ready = 1;
            @(posedge clk); #1;
            chk("bp_handshakes", hs - h0, 1);
            chk("bp_idle", int'(busy), 0);
            @(posedge clk); #1;
            chk("bp_stay_idle", int'(busy), 0);
            chk("bp_no_repeat", hs - h0, 1);
        end
        // gaps between beats
        job(3, 0, 0, 100, -30, 5, 2, 75, 1'b0);
        // asynchronous reset mid-job
        start_job(3, 0, 0);
        send(11);
        reset = 1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(psum_ready), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        @(posedge clk); #1 reset = 0;
        job(1, 0, 0, 7, 0, 0, 0, 7, 1'b0);
        // zero length is ignored
        start_job(0, 0, 0);
        psum_valid = 1; psum_data = 99;
        for (int i = 0; i < 4; i++) begin
            chk("len0_busy", int'(busy), 0);
            chk("len0_ready", int'(psum_ready), 0);
            chk("len0_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        psum_valid = 0;
        chk("scoreboard_empty", q.size(), 0);
        chk("total_handshakes", hs, 9);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
